id_stage: RTL and testbench

- Decode stage of the 5-stage RV32I pipeline, between the IF/ID register and the execute stage.
- Drives the register file read addresses from the incoming instruction and takes the two read data words combinationally.
- Decodes control fields and generates the immediate.
- Detects load-use hazards and registers everything into the ID/EX pipeline register, with stall and flush support.

---
 rtl/id_stage.sv | 190 +++++++++++++++++++
 tb/tb_id_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I decode stage: register-file addressing, control/immediate decode, load-use hazard
// detection and the ID/EX pipeline register with stall and flush.
module id_stage #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NOP_ON_ILLEGAL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    input  logic [XLEN-1:0] if_pc,
    input  logic            flush,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    output logic [4:0]      rf_rs1,
    output logic [4:0]      rf_rs2,
    input  logic [31:0]     rf_rdata1,
    input  logic [31:0]     rf_rdata2,
    output logic            stall,
    output logic            idex_valid,
    output logic [XLEN-1:0] idex_pc,
    output logic [31:0]     idex_rs1_data,
    output logic [31:0]     idex_rs2_data,
    output logic [31:0]     idex_imm,
    output logic [4:0]      idex_rs1,
    output logic [4:0]      idex_rs2,
    output logic [4:0]      idex_rd,
    output logic [6:0]      idex_opcode,
    output logic [2:0]      idex_funct3,
    output logic            idex_funct7b5,
    output logic            idex_reg_write,
    output logic            idex_mem_read,
    output logic            idex_mem_write,
    output logic            idex_branch,
    output logic            idex_jump,
    output logic            idex_illegal
);

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpBr    = 7'b1100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpAuipc = 7'b0010111;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpJalr  = 7'b1100111;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     rs1_data;
        logic [31:0]     rs2_data;
        logic [31:0]     imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [6:0]      opcode;
        logic [2:0]      funct3;
        logic            funct7b5;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            branch;
        logic            jump;
        logic            illegal;
    } idex_t;

    idex_t idex_d, idex_q;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic        uses_rs1, uses_rs2;
    logic [31:0] imm;
    logic        dec_reg_write, dec_mem_read, dec_mem_write, dec_branch, dec_jump;
    logic        dec_illegal, ctrl_en;
    logic        hazard, issue;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign rf_rs1 = if_instr[19:15];
    assign rf_rs2 = if_instr[24:20];

    always_comb begin
        uses_rs1      = !(opcode == OpLui || opcode == OpAuipc || opcode == OpJal);
        uses_rs2      = (opcode == OpR || opcode == OpStore || opcode == OpBr);
        imm           = '0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        dec_illegal   = 1'b0;
        case (opcode)
            OpR:   dec_reg_write = 1'b1;
            OpImm: begin
                imm           = {{20{if_instr[31]}}, if_instr[31:20]};
                dec_reg_write = 1'b1;
            end
            OpLoad: begin
                imm           = {{20{if_instr[31]}}, if_instr[31:20]};
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
            end
            OpJalr: begin
                imm           = {{20{if_instr[31]}}, if_instr[31:20]};
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
            end
            OpStore: begin
                imm           = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
                dec_mem_write = 1'b1;
            end
            OpBr: begin
                imm        = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                              if_instr[11:8], 1'b0};
                dec_branch = 1'b1;
            end
            OpLui, OpAuipc: begin
                imm           = {if_instr[31:12], 12'b0};
                dec_reg_write = 1'b1;
            end
            OpJal: begin
                imm           = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                                 if_instr[30:21], 1'b0};
                dec_reg_write = 1'b1;
                dec_jump      = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (rd == 5'd0) begin
            dec_reg_write = 1'b0;
        end
    end

    assign ctrl_en = !(dec_illegal && (NOP_ON_ILLEGAL != 0));

    // Flush kills the instruction, so it can never also be held by a stall.
    assign hazard = if_valid && !flush && ex_mem_read && (ex_rd != 5'd0) &&
                    ((uses_rs1 && rf_rs1 == ex_rd) || (uses_rs2 && rf_rs2 == ex_rd));
    assign stall  = hazard && !rst;
    assign issue  = if_valid && !flush && !hazard;

    always_comb begin
        idex_d.valid     = issue;
        idex_d.pc        = if_pc;
        idex_d.rs1_data  = rf_rdata1;
        idex_d.rs2_data  = rf_rdata2;
        idex_d.imm       = imm;
        idex_d.rs1       = rf_rs1;
        idex_d.rs2       = rf_rs2;
        idex_d.rd        = rd;
        idex_d.opcode    = opcode;
        idex_d.funct3    = if_instr[14:12];
        idex_d.funct7b5  = if_instr[30];
        idex_d.reg_write = issue && ctrl_en && dec_reg_write;
        idex_d.mem_read  = issue && ctrl_en && dec_mem_read;
        idex_d.mem_write = issue && ctrl_en && dec_mem_write;
        idex_d.branch    = issue && ctrl_en && dec_branch;
        idex_d.jump      = issue && ctrl_en && dec_jump;
        idex_d.illegal   = issue && dec_illegal;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign idex_valid     = idex_q.valid;
    assign idex_pc        = idex_q.pc;
    assign idex_rs1_data  = idex_q.rs1_data;
    assign idex_rs2_data  = idex_q.rs2_data;
    assign idex_imm       = idex_q.imm;
    assign idex_rs1       = idex_q.rs1;
    assign idex_rs2       = idex_q.rs2;
    assign idex_rd        = idex_q.rd;
    assign idex_opcode    = idex_q.opcode;
    assign idex_funct3    = idex_q.funct3;
    assign idex_funct7b5  = idex_q.funct7b5;
    assign idex_reg_write = idex_q.reg_write;
    assign idex_mem_read  = idex_q.mem_read;
    assign idex_mem_write = idex_q.mem_write;
    assign idex_branch    = idex_q.branch;
    assign idex_jump      = idex_q.jump;
    assign idex_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: decode, immediates, load-use stall, flush, illegal and reset.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        flush;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic [4:0]  rf_rs1, rf_rs2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        stall;
    logic        idex_valid;
    logic [31:0] idex_pc, idex_rs1_data, idex_rs2_data, idex_imm;
    logic [4:0]  idex_rs1, idex_rs2, idex_rd;
    logic [6:0]  idex_opcode;
    logic [2:0]  idex_funct3;
    logic        idex_funct7b5, idex_reg_write, idex_mem_read, idex_mem_write;
    logic        idex_branch, idex_jump, idex_illegal;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_stage #(.XLEN(32), .NOP_ON_ILLEGAL(1)) dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .stall(stall), .idex_valid(idex_valid), .idex_pc(idex_pc),
        .idex_rs1_data(idex_rs1_data), .idex_rs2_data(idex_rs2_data), .idex_imm(idex_imm),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .idex_rd(idex_rd),
        .idex_opcode(idex_opcode), .idex_funct3(idex_funct3), .idex_funct7b5(idex_funct7b5),
        .idex_reg_write(idex_reg_write), .idex_mem_read(idex_mem_read),
        .idex_mem_write(idex_mem_write), .idex_branch(idex_branch), .idex_jump(idex_jump),
        .idex_illegal(idex_illegal)
    );

    // Packed view of the control bits: {reg_write, mem_read, mem_write, branch, jump, illegal}
    logic [5:0] ctrl;
    assign ctrl = {idex_reg_write, idex_mem_read, idex_mem_write, idex_branch, idex_jump,
                   idex_illegal};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        @(negedge clk);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_valid = 1'b1; if_instr = 32'h001101B3; if_pc = 32'h0;
        flush = 1'b0; ex_mem_read = 1'b1; ex_rd = 5'd2;
        rf_rdata1 = 32'h0; rf_rdata2 = 32'h0;
        #1;
        check("stall_in_reset", {31'b0, stall}, 32'd0);
        tick();
        check("reset_valid", {31'b0, idex_valid}, 32'd0);
        check("reset_ctrl", {26'b0, ctrl}, 32'd0);
        check("reset_imm", idex_imm, 32'd0);
        check("reset_rd", {27'b0, idex_rd}, 32'd0);

        // addi x1,x0,5
        @(negedge clk);
        rst = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
        rf_rdata1 = 32'h0; rf_rdata2 = 32'h0BAD_0BAD;
        drive(1'b1, 32'h00500093, 32'h0000_0040);
        check("addi_rf_rs1", {27'b0, rf_rs1}, 32'd0);
        check("addi_rf_rs2", {27'b0, rf_rs2}, 32'd5);
        tick();
        check("addi_valid", {31'b0, idex_valid}, 32'd1);
        check("addi_imm", idex_imm, 32'd5);
        check("addi_rd", {27'b0, idex_rd}, 32'd1);
        check("addi_ctrl", {26'b0, ctrl}, 32'b100000);
        check("addi_rs1_data", idex_rs1_data, 32'd0);
        check("addi_pc", idex_pc, 32'h40);

        // add x3,x2,x1 behind a load to x2
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd2;
        rf_rdata1 = 32'h1111_1111; rf_rdata2 = 32'h2222_2222;
        drive(1'b1, 32'h001101B3, 32'h0000_0044);
        check("lu_rs1_stall", {31'b0, stall}, 32'd1);
        check("lu_rf_rs1", {27'b0, rf_rs1}, 32'd2);
        tick();
        check("lu_bubble_valid", {31'b0, idex_valid}, 32'd0);
        check("lu_bubble_ctrl", {26'b0, ctrl}, 32'd0);
        @(negedge clk);
        ex_rd = 5'd1; #1;
        check("lu_rs2_stall", {31'b0, stall}, 32'd1);
        ex_mem_read = 1'b0; #1;
        check("lu_release", {31'b0, stall}, 32'd0);
        tick();
        check("add_valid", {31'b0, idex_valid}, 32'd1);
        check("add_rd", {27'b0, idex_rd}, 32'd3);
        check("add_ctrl", {26'b0, ctrl}, 32'b100000);
        check("add_rs1_data", idex_rs1_data, 32'h1111_1111);
        check("add_rs2_data", idex_rs2_data, 32'h2222_2222);
        check("add_rs1", {27'b0, idex_rs1}, 32'd2);
        check("add_rs2", {27'b0, idex_rs2}, 32'd1);
        check("add_opcode", {25'b0, idex_opcode}, 32'h33);

        // lui x5,0x12345: rs1 field is 8 but LUI reads no registers
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        drive(1'b1, 32'h123452B7, 32'h0000_0048);
        check("lui_stall_rd5", {31'b0, stall}, 32'd0);
        ex_rd = 5'd8; #1;
        check("lui_stall_rs1field", {31'b0, stall}, 32'd0);
        tick();
        check("lui_imm", idex_imm, 32'h1234_5000);
        check("lui_rd", {27'b0, idex_rd}, 32'd5);
        check("lui_valid", {31'b0, idex_valid}, 32'd1);

        // beq x0,x0,-4
        @(negedge clk);
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        drive(1'b1, 32'hFE000EE3, 32'h0000_0100);
        tick();
        check("beq_imm", idex_imm, 32'hFFFF_FFFC);
        check("beq_ctrl", {26'b0, ctrl}, 32'b000100);
        check("beq_pc", idex_pc, 32'h100);

        // sw x2,8(x1)
        drive(1'b1, 32'h0020A423, 32'h0000_0104);
        tick();
        check("sw_imm", idex_imm, 32'd8);
        check("sw_ctrl", {26'b0, ctrl}, 32'b001000);
        check("sw_funct3", {29'b0, idex_funct3}, 32'd2);

        // lw x4,-8(x1)
        drive(1'b1, 32'hFF80A203, 32'h0000_0108);
        tick();
        check("lw_imm", idex_imm, 32'hFFFF_FFF8);
        check("lw_ctrl", {26'b0, ctrl}, 32'b110000);
        check("lw_rd", {27'b0, idex_rd}, 32'd4);

        // jal x1,16
        drive(1'b1, 32'h010000EF, 32'h0000_010C);
        tick();
        check("jal_imm", idex_imm, 32'd16);
        check("jal_ctrl", {26'b0, ctrl}, 32'b100010);

        // flush coincident with a load-use hazard
        @(negedge clk);
        ex_mem_read = 1'b1; ex_rd = 5'd2; flush = 1'b1;
        drive(1'b1, 32'h001101B3, 32'h0000_0110);
        check("flush_hazard_stall", {31'b0, stall}, 32'd0);
        tick();
        check("flush_valid", {31'b0, idex_valid}, 32'd0);
        check("flush_ctrl", {26'b0, ctrl}, 32'd0);

        // if_valid=0 with the hazard condition present
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h001101B3, 32'h0000_0110);
        check("invalid_stall", {31'b0, stall}, 32'd0);
        tick();
        check("invalid_valid", {31'b0, idex_valid}, 32'd0);
        check("invalid_ctrl", {26'b0, ctrl}, 32'd0);

        // illegal opcodes
        @(negedge clk);
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        drive(1'b1, 32'h0000007F, 32'h0000_0114);
        tick();
        check("ill7f_valid", {31'b0, idex_valid}, 32'd1);
        check("ill7f_ctrl", {26'b0, ctrl}, 32'b000001);
        drive(1'b1, 32'h00000FFF, 32'h0000_0118);
        tick();
        check("illfff_ctrl", {26'b0, ctrl}, 32'b000001);
        check("illfff_rd", {27'b0, idex_rd}, 32'd31);

        // addi x0,x0,1
        drive(1'b1, 32'h00100013, 32'h0000_011C);
        tick();
        check("x0_valid", {31'b0, idex_valid}, 32'd1);
        check("x0_ctrl", {26'b0, ctrl}, 32'd0);
        check("x0_imm", idex_imm, 32'd1);

        // reset mid-stream while a hazard is present
        @(negedge clk);
        rst = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd2;
        drive(1'b1, 32'h001101B3, 32'h0000_0120);
        check("midrst_stall", {31'b0, stall}, 32'd0);
        tick();
        check("midrst_valid", {31'b0, idex_valid}, 32'd0);
        check("midrst_ctrl", {26'b0, ctrl}, 32'd0);
        check("midrst_pc", idex_pc, 32'd0);
        check("midrst_imm", idex_imm, 32'd0);
        check("midrst_data", idex_rs1_data | idex_rs2_data, 32'd0);
        check("midrst_fields", {4'b0, idex_rs1, idex_rs2, idex_rd, idex_opcode, idex_funct3,
                                idex_funct7b5}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
